// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Looked up in IF and trained in ID. Also drives mispredict redirects and statistics counters.
module branch_predictor #(
  parameter int IDX_W = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] if_pc,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic [31:0] branch_cnt,
  output logic [31:0] mispred_cnt
);

  localparam int DEPTH = 1 << IDX_W;
  localparam int TAG_W = 32 - IDX_W - 2;

  logic             valid_q  [DEPTH];
  logic [TAG_W-1:0] tag_q    [DEPTH];
  logic [31:0]      target_q [DEPTH];
  logic [1:0]       ctr_q    [DEPTH];

  logic [IDX_W-1:0] if_idx;
  logic [TAG_W-1:0] if_tag;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;
  logic             unused_pc_bits;

  assign if_idx  = if_pc[IDX_W+1:2];
  assign if_tag  = if_pc[31:IDX_W+2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[31:IDX_W+2];
  assign unused_pc_bits = ^{if_pc[1:0], upd_pc[1:0]};

  // Lookup sees only registered contents, so a same-cycle update is not bypassed.
  assign pred_hit    = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign pred_taken  = pred_hit && ctr_q[if_idx][1];
  assign pred_target = pred_hit ? target_q[if_idx] : 32'd0;

  assign upd_hit     = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  // Fall-through skips the delay slot, so it is branch PC + 8.
  assign redirect    = upd_valid && (upd_taken != upd_pred_taken);
  assign redirect_pc = !redirect ? 32'd0 :
                       upd_taken ? upd_target : (upd_pc + 32'd8);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= 32'd0;
        ctr_q[i]    <= 2'b01;
      end
      branch_cnt  <= 32'd0;
      mispred_cnt <= 32'd0;
    end else if (upd_valid) begin
      branch_cnt <= branch_cnt + 32'd1;
      if (redirect) begin
        mispred_cnt <= mispred_cnt + 32'd1;
      end
      if (upd_hit) begin
        if (upd_taken) begin
          if (ctr_q[upd_idx] != 2'b11) begin
            ctr_q[upd_idx] <= ctr_q[upd_idx] + 2'b01;
          end
          target_q[upd_idx] <= upd_target;
        end else if (ctr_q[upd_idx] != 2'b00) begin
          ctr_q[upd_idx] <= ctr_q[upd_idx] - 2'b01;
        end
      end else if (upd_taken) begin
        // A taken miss always claims the slot, evicting any alias.
        valid_q[upd_idx]  <= 1'b1;
        tag_q[upd_idx]    <= upd_tag;
        target_q[upd_idx] <= upd_target;
        ctr_q[upd_idx]    <= 2'b10;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: training, saturation, aliasing, redirects and reset priority.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] if_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] branch_cnt;
  logic [31:0] mispred_cnt;

  int total = 0;
  int bad   = 0;

  branch_predictor #(.IDX_W(6)) dut (
    .clk(clk),
    .reset(reset),
    .if_pc(if_pc),
    .pred_hit(pred_hit),
    .pred_taken(pred_taken),
    .pred_target(pred_target),
    .upd_valid(upd_valid),
    .upd_pc(upd_pc),
    .upd_taken(upd_taken),
    .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .branch_cnt(branch_cnt),
    .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic v, input logic [31:0] pc, input logic t,
                                input logic [31:0] tgt, input logic p);
    upd_valid      = v;
    upd_pc         = pc;
    upd_taken      = t;
    upd_target     = tgt;
    upd_pred_taken = p;
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic look(input logic [31:0] pc);
    if_pc = pc;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    if_pc = 32'd0;
    apply_stimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    tick();
    tick();
    reset = 1'b0;

    look(32'h0040_0010);
    check_output("rst_hit", {31'd0, pred_hit}, 32'd0);
    check_output("rst_taken", {31'd0, pred_taken}, 32'd0);
    check_output("rst_target", pred_target, 32'd0);
    check_output("rst_redirect", {31'd0, redirect}, 32'd0);
    check_output("rst_redirect_pc", redirect_pc, 32'd0);
    check_output("rst_branch_cnt", branch_cnt, 32'd0);
    check_output("rst_mispred_cnt", mispred_cnt, 32'd0);

    // First taken branch on a miss: mispredict, and the same-cycle lookup still misses
    apply_stimulus(1'b1, 32'h0040_0010, 1'b1, 32'h0040_0040, 1'b0);
    check_output("first_redirect", {31'd0, redirect}, 32'd1);
    check_output("first_redirect_pc", redirect_pc, 32'h0040_0040);
    check_output("same_cycle_old_hit", {31'd0, pred_hit}, 32'd0);
    tick();
    apply_stimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    check_output("alloc_hit", {31'd0, pred_hit}, 32'd1);
    check_output("alloc_taken", {31'd0, pred_taken}, 32'd1);
    check_output("alloc_target", pred_target, 32'h0040_0040);
    check_output("alloc_mispred_cnt", mispred_cnt, 32'd1);

    // Three more taken: ctr 2 -> 3 -> 3 -> 3
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, 32'h0040_0010, 1'b1, 32'h0040_0040, 1'b1);
      check_output("train_t_redirect", {31'd0, redirect}, 32'd0);
      tick();
    end
    // Two not-taken: ctr 3 -> 2 -> 1
    apply_stimulus(1'b1, 32'h0040_0010, 1'b0, 32'd0, 1'b0);
    tick();
    apply_stimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    check_output("sat3_nt1_taken", {31'd0, pred_taken}, 32'd1);
    apply_stimulus(1'b1, 32'h0040_0010, 1'b0, 32'd0, 1'b0);
    tick();
    apply_stimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    check_output("nt2_taken", {31'd0, pred_taken}, 32'd0);
    check_output("nt2_hit", {31'd0, pred_hit}, 32'd1);
    check_output("train_branch_cnt", branch_cnt, 32'd6);
    check_output("train_mispred_cnt", mispred_cnt, 32'd1);

    // Not-taken on a miss leaves the table alone
    apply_stimulus(1'b1, 32'h0040_0020, 1'b0, 32'd0, 1'b0);
    check_output("nt_miss_redirect", {31'd0, redirect}, 32'd0);
    check_output("nt_miss_redirect_pc", redirect_pc, 32'd0);
    tick();
    look(32'h0040_0020);
    check_output("nt_miss_lookup_hit", {31'd0, pred_hit}, 32'd0);
    apply_stimulus(1'b1, 32'h0040_0020, 1'b0, 32'd0, 1'b1);
    check_output("nt_mispred_redirect", {31'd0, redirect}, 32'd1);
    check_output("nt_mispred_redirect_pc", redirect_pc, 32'h0040_0028);
    tick();
    apply_stimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    check_output("nt_branch_cnt", branch_cnt, 32'd8);
    check_output("nt_mispred_cnt", mispred_cnt, 32'd2);

    // Floor saturation: ctr 1 -> 0 -> 0, then two taken reach 2 only if it stayed at 0
    look(32'h0040_0010);
    for (int i = 0; i < 2; i++) begin
      apply_stimulus(1'b1, 32'h0040_0010, 1'b0, 32'd0, 1'b0);
      tick();
    end
    apply_stimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    check_output("sat0_hit", {31'd0, pred_hit}, 32'd1);
    check_output("sat0_target", pred_target, 32'h0040_0040);
    for (int i = 0; i < 2; i++) begin
      apply_stimulus(1'b1, 32'h0040_0010, 1'b1, 32'h0040_0040, 1'b1);
      tick();
    end
    apply_stimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    check_output("sat0_recover_taken", {31'd0, pred_taken}, 32'd1);

    // Alias at the same index with a different tag replaces the entry
    apply_stimulus(1'b1, 32'h0040_0110, 1'b1, 32'h0050_0000, 1'b0);
    check_output("alias_redirect_pc", redirect_pc, 32'h0050_0000);
    tick();
    apply_stimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    look(32'h0040_0010);
    check_output("alias_orig_hit", {31'd0, pred_hit}, 32'd0);
    look(32'h0040_0110);
    check_output("alias_hit", {31'd0, pred_hit}, 32'd1);
    check_output("alias_taken", {31'd0, pred_taken}, 32'd1);
    check_output("alias_target", pred_target, 32'h0050_0000);
    apply_stimulus(1'b1, 32'h0040_0110, 1'b0, 32'd0, 1'b0);
    tick();
    apply_stimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    check_output("alias_ctr2_taken", {31'd0, pred_taken}, 32'd0);
    check_output("alias_branch_cnt", branch_cnt, 32'd14);
    check_output("alias_mispred_cnt", mispred_cnt, 32'd3);

    // Fall-through adder wraps at 32 bits (combinational only, not clocked in)
    apply_stimulus(1'b1, 32'hFFFF_FFFC, 1'b0, 32'd0, 1'b1);
    check_output("wrap_redirect_pc", redirect_pc, 32'h0000_0004);
    apply_stimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);

    // Reset wins over a simultaneous update
    reset = 1'b1;
    apply_stimulus(1'b1, 32'h0040_0010, 1'b1, 32'h0040_0080, 1'b0);
    tick();
    reset = 1'b0;
    apply_stimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    check_output("rst_upd_branch_cnt", branch_cnt, 32'd0);
    check_output("rst_upd_mispred_cnt", mispred_cnt, 32'd0);
    look(32'h0040_0010);
    check_output("rst_upd_hit", {31'd0, pred_hit}, 32'd0);
    look(32'h0040_0110);
    check_output("rst_alias_hit", {31'd0, pred_hit}, 32'd0);
    check_output("rst_alias_target", pred_target, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
